ddr3_ring_fifo_master: RTL and testbench

DDR3-backed streaming FIFO that acts as the host-side initiator of the DDR3 core's burst request interface: wr_request/wr_addr/wr_num/wr_data in, wr_allow/wr_finish/wr_busy back, and the same set for reads. It buffers an input stream in a small on-chip write FIFO and drains it to a ring region in DDR3 in fixed bursts. It reads bursts back in order into an on-chip read FIFO for an output stream. It sits between the user datapath and the DDR3 core, on the core's user clock.

---
 rtl/ddr3_ring_pkg.sv | 18 +
 rtl/ddr3_sync_fifo_fwft.sv | 54 +++++
 rtl/ddr3_ring_fifo_master.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr3_ring_fifo_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ring_pkg.sv
// Shared types and constants for the DDR3 ring FIFO master.
package ddr3_ring_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    GAP     = 2'd3
  } ring_state_t;

  // Core addresses count 8 bytes... per word slot, so one word advances the address by 8.
  localparam int unsigned ADDR_STEP = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered occupancy (count) and free-space (free).
module ddr3_sync_fifo_fwft #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic [AW:0]      free
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != DEPTH);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign free    = DEPTH - count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr3_ring_fifo_master.sv
// Streaming FIFO that parks bursts in a DDR3 ring region via the core's burst request interface.
// Optional status ports (ring_level, ring_full, bursts_done) under `DDR3_RING_STATUS_EN.
module ddr3_ring_fifo_master
  import ddr3_ring_pkg::*;
#(
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned BURST_LEN      = 64,
  parameter int unsigned REGION_BASE    = 0,
  parameter int unsigned REGION_BURSTS  = 4096,
  parameter int unsigned FIFO_AW        = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_calib_complete,
  input  logic                      clear,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [APP_DATA_WIDTH-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [APP_DATA_WIDTH-1:0] m_data,
  output logic                      wr_request,
  output logic [APP_ADDR_WIDTH-1:0] wr_addr,
  output logic [9:0]                wr_num,
  output logic [APP_DATA_WIDTH-1:0] wr_data,
  input  logic                      wr_allow,
  input  logic                      wr_finish,
  input  logic                      wr_busy,
  output logic                      rd_request,
  output logic [APP_ADDR_WIDTH-1:0] rd_addr,
  output logic [9:0]                rd_num,
  input  logic [APP_DATA_WIDTH-1:0] rd_data,
  input  logic                      rd_allow,
  input  logic                      rd_finish,
  input  logic                      rd_busy
`ifdef DDR3_RING_STATUS_EN
  ,
  output logic [$clog2(REGION_BURSTS+1)-1:0] ring_level,
  output logic                               ring_full,
  output logic [31:0]                        bursts_done
`endif
);

  localparam int unsigned PW         = idx_width(REGION_BURSTS);
  localparam int unsigned LW         = $clog2(REGION_BURSTS + 1);
  localparam int unsigned ADDR_SHIFT = $clog2(BURST_LEN) + $clog2(ADDR_STEP);

  localparam logic [FIFO_AW:0]         BURST_CNT = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [LW-1:0]            LEVEL_MAX = LW'(REGION_BURSTS);
  localparam logic [PW-1:0]            PTR_LAST  = PW'(REGION_BURSTS - 1);
  localparam logic [9:0]               BURST_NUM = 10'(BURST_LEN);
  localparam logic [10:0]              BEATS     = 11'(BURST_LEN);
  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_BASE = APP_ADDR_WIDTH'(REGION_BASE);

  ring_state_t state, state_next;

  logic [PW-1:0]      wp, rp;
  logic [LW-1:0]      level;
  logic               last_wr;
  logic               clear_pending;
  logic               run;
  logic [10:0]        wr_beats;
  logic [FIFO_AW:0]   wfifo_count, wfifo_free;
  logic [FIFO_AW:0]   rfifo_count, rfifo_free;
  logic               wr_elig, rd_elig, pick_wr, pick_rd;
  logic               start_wr, start_rd, wr_done, rd_done;
  logic               do_clear, latch_clear;

  function automatic logic [APP_ADDR_WIDTH-1:0] burst_addr(input logic [PW-1:0] idx);
    return ADDR_BASE + (APP_ADDR_WIDTH'(idx) << ADDR_SHIFT);
  endfunction

  function automatic logic [PW-1:0] ring_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  ddr3_sync_fifo_fwft #(.WIDTH(APP_DATA_WIDTH), .AW(FIFO_AW)) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (do_clear),
    .push      (s_valid && s_ready),
    .push_data (s_data),
    .pop       (wr_allow),
    .head      (wr_data),
    .count     (wfifo_count),
    .free      (wfifo_free)
  );

  ddr3_sync_fifo_fwft #(.WIDTH(APP_DATA_WIDTH), .AW(FIFO_AW)) u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (do_clear),
    .push      (rd_allow),
    .push_data (rd_data),
    .pop       (m_valid && m_ready),
    .head      (m_data),
    .count     (rfifo_count),
    .free      (rfifo_free)
  );

  assign s_ready = run && (wfifo_free != '0);
  assign m_valid = (rfifo_count != '0);

  assign wr_elig = (wfifo_count >= BURST_CNT) && (level < LEVEL_MAX);
  assign rd_elig = (level != '0) && (rfifo_free >= BURST_CNT);
  // Round-robin on a tie: last_wr set means the previous grant was a write.
  assign pick_wr = wr_elig && (!rd_elig || !last_wr);
  assign pick_rd = rd_elig && (!wr_elig || last_wr);

  always_comb begin
    state_next  = state;
    start_wr    = 1'b0;
    start_rd    = 1'b0;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    do_clear    = 1'b0;
    latch_clear = 1'b0;
    case (state)
      IDLE: begin
        if (clear || clear_pending) begin
          do_clear = 1'b1;
        end else if (init_calib_complete && pick_wr) begin
          start_wr   = 1'b1;
          state_next = WR_BUSY;
        end else if (init_calib_complete && pick_rd) begin
          start_rd   = 1'b1;
          state_next = RD_BUSY;
        end
      end
      WR_BUSY: begin
        latch_clear = clear;
        if (wr_finish) begin
          wr_done    = 1'b1;
          state_next = GAP;
        end
      end
      RD_BUSY: begin
        latch_clear = clear;
        if (rd_finish) begin
          rd_done    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        do_clear   = clear || clear_pending;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      run           <= 1'b0;
      wr_request    <= 1'b0;
      rd_request    <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_num        <= '0;
      rd_num        <= '0;
      wp            <= '0;
      rp            <= '0;
      level         <= '0;
      last_wr       <= 1'b0;
      clear_pending <= 1'b0;
      wr_beats      <= '0;
    end else begin
      state <= state_next;
      run   <= 1'b1;

      if (start_wr) begin
        wr_request <= 1'b1;
        wr_addr    <= burst_addr(wp);
        wr_num     <= BURST_NUM;
        last_wr    <= 1'b1;
      end
      if (start_rd) begin
        rd_request <= 1'b1;
        rd_addr    <= burst_addr(rp);
        rd_num     <= BURST_NUM;
        last_wr    <= 1'b0;
      end
      if (wr_done) begin
        wr_request <= 1'b0;
        wp         <= ring_next(wp);
        level      <= level + 1'b1;
      end
      if (rd_done) begin
        rd_request <= 1'b0;
        rp         <= ring_next(rp);
        level      <= level - 1'b1;
      end
      // A clear seen mid-burst is held until the burst has fully retired through GAP.
      if (do_clear) begin
        wp    <= '0;
        rp    <= '0;
        level <= '0;
      end

      if (do_clear)         clear_pending <= 1'b0;
      else if (latch_clear) clear_pending <= 1'b1;

      if (start_wr)      wr_beats <= '0;
      else if (wr_allow) wr_beats <= wr_beats + 1'b1;

      if (state == WR_BUSY && wr_finish)
        assert (wr_beats + 11'(wr_allow) == BEATS)
          else $error("write burst retired after %0d beats", wr_beats + 11'(wr_allow));
      assert (!(rd_allow && rfifo_free == '0))
        else $error("rd_allow while read FIFO is full");
      assert (!(wr_busy && rd_busy))
        else $error("core reports both directions busy");
    end
  end

`ifdef DDR3_RING_STATUS_EN
  assign ring_level = level;
  assign ring_full  = (level == LEVEL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    bursts_done <= '0;
    else if (wr_done || rd_done) bursts_done <= bursts_done + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ddr3_ring_fifo_master.sv
// Directed self-checking bench for ddr3_ring_fifo_master with a behavioural DDR3 core model.
module tb_ddr3_ring_fifo_master;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int BL = 64;

  logic          clk = 1'b0;
  logic          rst, init_calib_complete, clear;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, wr_data, rd_data;
  logic          wr_request, rd_request;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [9:0]    wr_num, rd_num;
  logic          wr_allow, wr_finish, wr_busy, rd_allow, rd_finish, rd_busy;
`ifdef DDR3_RING_STATUS_EN
  logic [2:0]    ring_level;
  logic          ring_full;
  logic [31:0]   bursts_done;
`endif

  ddr3_ring_fifo_master #(
    .APP_DATA_WIDTH (DW),
    .APP_ADDR_WIDTH (AW),
    .BURST_LEN      (BL),
    .REGION_BASE    (0),
    .REGION_BURSTS  (4),
    .FIFO_AW        (7)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .clear               (clear),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_data              (m_data),
    .wr_request          (wr_request),
    .wr_addr             (wr_addr),
    .wr_num              (wr_num),
    .wr_data             (wr_data),
    .wr_allow            (wr_allow),
    .wr_finish           (wr_finish),
    .wr_busy             (wr_busy),
    .rd_request          (rd_request),
    .rd_addr             (rd_addr),
    .rd_num              (rd_num),
    .rd_data             (rd_data),
    .rd_allow            (rd_allow),
    .rd_finish           (rd_finish),
    .rd_busy             (rd_busy)
`ifdef DDR3_RING_STATUS_EN
    ,
    .ring_level          (ring_level),
    .ring_full           (ring_full),
    .bursts_done         (bursts_done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int drop_bad = 0;
  bit wr_active = 0;

  logic [AW-1:0] wr_log[$], rd_log[$];
  logic [9:0]    wr_num_log[$], rd_num_log[$];
  int            wr_fin_cyc[$], rd_start_cyc[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] ddr [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] waddr(input int i);
    if (i < wr_log.size()) return 64'(wr_log[i]);
    return {64{1'bx}};
  endfunction

  function automatic logic [63:0] raddr(input int i);
    if (i < rd_log.size()) return 64'(rd_log[i]);
    return {64{1'bx}};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic feed(input int n, input int unsigned first, input int limit, output int got);
    bit acc;
    got = 0;
    for (int c = 0; c < limit && got < n; c++) begin
      s_valid = 1'b1;
      s_data  = DW'(first + got);
      acc     = s_ready;
      @(negedge clk);
      if (acc) got++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int limit);
    for (int c = 0; c < limit && out_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); wr_num_log.delete(); rd_num_log.delete();
    wr_fin_cyc.delete(); rd_start_cyc.delete(); out_q.delete();
  endtask

  // DDR3 core model: one burst at a time, two cycles of latency, then BL beats and a finish pulse.
  initial begin
    wr_allow = 0; wr_finish = 0; wr_busy = 0;
    rd_allow = 0; rd_finish = 0; rd_busy = 0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && wr_request) begin
        int base;
        bit ab;
        ab = 0;
        base = int'(wr_addr >> 3);
        wr_log.push_back(wr_addr);
        wr_num_log.push_back(wr_num);
        wr_busy = 1;
        @(negedge clk);
        for (int i = 0; i < BL; i++) begin
          if (rst) begin ab = 1; break; end
          wr_allow  = 1;
          wr_active = 1;
          ddr[(base + i) % 256] = wr_data;
          @(negedge clk);
        end
        wr_allow  = 0;
        wr_active = 0;
        if (!ab && !rst) begin
          wr_finish = 1;
          wr_fin_cyc.push_back(cyc);
          @(negedge clk);
          wr_finish = 0;
          if (wr_request !== 1'b0) drop_bad++;
        end
        wr_busy = 0;
      end else if (!rst && rd_request) begin
        int base;
        bit ab;
        ab = 0;
        base = int'(rd_addr >> 3);
        rd_log.push_back(rd_addr);
        rd_num_log.push_back(rd_num);
        rd_start_cyc.push_back(cyc);
        rd_busy = 1;
        @(negedge clk);
        for (int i = 0; i < BL; i++) begin
          if (rst) begin ab = 1; break; end
          rd_allow = 1;
          rd_data  = ddr[(base + i) % 256];
          @(negedge clk);
        end
        rd_allow = 0;
        if (!ab && !rst) begin
          rd_finish = 1;
          @(negedge clk);
          rd_finish = 0;
          if (rd_request !== 1'b0) drop_bad++;
        end
        rd_busy = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (m_valid && m_ready) out_q.push_back(m_data);
    end
  end

  initial begin
    int got, n0, err;
    rst = 1; init_calib_complete = 0; clear = 0;
    s_valid = 0; s_data = '0; m_ready = 0;
    wait_cycles(3);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_request", wr_request, 0);
    check("rst_rd_request", rd_request, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    rst = 0;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1);
    init_calib_complete = 1;

    // 63 words are one short of a burst
    feed(63, 0, 200, got);
    check("feed63_accepted", got, 63);
    wait_cycles(100);
    check("feed63_no_write", wr_log.size(), 0);
    check("feed63_s_ready", s_ready, 1);
    check("feed63_m_valid", m_valid, 0);

    m_ready = 1;
    feed(1, 63, 20, got);
    wait_out(64, 1000);
    wait_cycles(10);
    check("A_wr_count", wr_log.size(), 1);
    check("A_wr_addr", waddr(0), 0);
    check("A_wr_num", (wr_num_log.size() > 0) ? 64'(wr_num_log[0]) : {64{1'bx}}, 64);
    check("A_rd_count", rd_log.size(), 1);
    check("A_rd_addr", raddr(0), 0);
    check("A_rd_num", (rd_num_log.size() > 0) ? 64'(rd_num_log[0]) : {64{1'bx}}, 64);
    check("A_finish_to_next_req",
          (rd_start_cyc.size() > 0 && wr_fin_cyc.size() > 0) ? 64'(rd_start_cyc[0] - wr_fin_cyc[0]) : {64{1'bx}}, 3);
    check("A_out_count", out_q.size(), 64);
    err = 0;
    for (int i = 0; i < 64; i++) if (i >= out_q.size() || out_q[i] !== DW'(i)) err++;
    check("A_out_data", err, 0);

    clear = 1;
    @(negedge clk);
    clear = 0;
    wait_cycles(5);

    // Saturate ring (4), read FIFO (2 bursts) and write FIFO (2 bursts) with the output stalled
    clear_logs();
    m_ready = 0;
    feed(1000, 1000, 2500, got);
    check("B_accepted", got, 512);
    check("B_s_ready_low", s_ready, 0);
    check("B_wr_count", wr_log.size(), 6);
    check("B_wr_wrap_addr", waddr(4), 0);
    err = 0;
    for (int i = 0; i < 6; i++) if (waddr(i) !== 64'((i % 4) * 512)) err++;
    check("B_wr_addrs", err, 0);
    check("B_rd_count", rd_log.size(), 2);
    err = 0;
    for (int i = 0; i < 2; i++) if (raddr(i) !== 64'(i * 512)) err++;
    check("B_rd_addrs", err, 0);
    check("B_no_request", {wr_request, rd_request}, 0);
    check("B_m_valid", m_valid, 1);
    check("B_out_empty", out_q.size(), 0);

    // Drain with more input; output must be the whole input sequence in order
    m_ready = 1;
    feed(128, 1512, 2000, got);
    check("C_accepted", got, 128);
    wait_out(640, 3000);
    wait_cycles(10);
    check("C_out_count", out_q.size(), 640);
    err = 0;
    for (int i = 0; i < 640; i++) if (i >= out_q.size() || out_q[i] !== DW'(1000 + i)) err++;
    check("C_out_data", err, 0);
    check("C_wr_count", wr_log.size(), 10);
    check("C_rd_count", rd_log.size(), 10);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (waddr(i) !== 64'((i % 4) * 512)) err++;
      if (raddr(i) !== 64'((i % 4) * 512)) err++;
    end
    check("C_addrs", err, 0);
    check("C_m_valid_idle", m_valid, 0);

    // Clear during a write burst: burst completes, then the ring is empty and pointers restart
    clear_logs();
    feed(64, 5000, 200, got);
    for (int c = 0; c < 300 && !wr_active; c++) @(negedge clk);
    wait_cycles(10);
    clear = 1;
    @(negedge clk);
    clear = 0;
    for (int c = 0; c < 300 && wr_fin_cyc.size() < 1; c++) @(negedge clk);
    wait_cycles(200);
    check("D_wr_count", wr_log.size(), 1);
    check("D_wr_addr", waddr(0), 1024);
    check("D_no_read", rd_log.size(), 0);
    check("D_m_valid", m_valid, 0);
    feed(64, 6000, 200, got);
    wait_out(64, 1000);
    wait_cycles(10);
    check("D_wr_addr_after", waddr(1), 0);
    check("D_rd_addr_after", raddr(0), 0);
    err = 0;
    for (int i = 0; i < 64; i++) if (i >= out_q.size() || out_q[i] !== DW'(6000 + i)) err++;
    check("D_out_data", err + out_q.size(), 64);

    // Reset during a write burst, then stay uncalibrated
    clear_logs();
    feed(64, 7000, 200, got);
    for (int c = 0; c < 300 && !wr_active; c++) @(negedge clk);
    wait_cycles(5);
    rst = 1;
    init_calib_complete = 0;
    #1;
    check("E_rst_wr_request", wr_request, 0);
    check("E_rst_rd_request", rd_request, 0);
    check("E_rst_s_ready", s_ready, 0);
    repeat (5) @(negedge clk);
    rst = 0;
    n0 = wr_log.size();
    feed(64, 8000, 200, got);
    check("E_accepted", got, 64);
    wait_cycles(200);
    check("E_no_new_request", wr_log.size(), n0);
    check("E_wr_request_low", wr_request, 0);
    check("E_drop_on_finish", drop_bad, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
